uncache_mmio_split: RTL and testbench
=====================================

# uncache_mmio_split

Parametrised uncached/MMIO access splitter between the core LSU and the memory arbiter. Routes cacheable accesses straight to the dcache and serialises uncached device accesses (UART, SPI, CLINT, and any other configured region) into one or two bus beats of `BUS_W` bits through a registered state machine. It assembles read data and returns a single-cycle completion pulse to the core. Region decoding is a parameter table, not fixed constants.

## Interface
Parameters:
- `BUS_W`, 32: arbiter beat width, 32 or 64; 64 means one beat per access.
- `NUM_RGN`, 4: number of uncached address regions.
- `RGN_BASE`, {UART, SPICTRL, SPI, CLINT starts}: packed `NUM_RGN*64` inclusive region bases; region i is in bits [64i+63:64i].
- `RGN_END`, {matching ends}: packed `NUM_RGN*64` inclusive region ends.
- `CLINT_RGN`, 3: index of the region that drives the CLINT code on `mmio_sign`.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `mmio_sign` out 3: 3'b010 when (re|we) hits `CLINT_RGN`, else 3'b100. Combinational.
- `core_addr`, `core_data` in 64; `core_mask` in 8: LSU request.
- `core_we`, `core_re`, `fence_in` in 1 each.
- `in_core_data` out 64; `in_core_finish` out 1: LSU response.
- `arb_addr`, `arb_data` out 64; `arb_mask` out 8; `arb_we`, `arb_re` out 1 each: arbiter request.
- `in_arb_data` in 64; `in_arb_finish` in 1: arbiter response.
- `dcache_addr`, `dcache_data` out 64; `dcache_mask` out 8; `dcache_we`, `dcache_re`, `dcache_fence` out 1 each: dcache request.
- `in_dcache_data` in 64; `in_dcache_finish` in 1: dcache response.

## Operation
- `uncache` is the OR over all regions of (`RGN_BASE[i]` ≤ `core_addr` ≤ `RGN_END[i]`).
- Cached path (`uncache`=0): all `dcache_*` signals mirror the core request combinationally.
  - `in_core_data` = `in_dcache_data`; `in_core_finish` = `in_dcache_finish`.
  - When `uncache`=1, `dcache_*` outputs are 0.
  - `dcache_fence` = `fence_in` always.
- Uncached FSM states:
  - IDLE → LOAD when `uncache` & (re|we). `core_we` has priority if both re and we are set. The FSM captures addr, data, mask and direction.
  - LOAD computes the beat list.
    - `BUS_W`=32: beat 0 (low word) if `mask[3:0]`≠0, then beat 1 (high word) if `mask[7:4]`≠0. Low word always goes first.
    - `BUS_W`=64: one beat.
    - mask==0 goes directly to DONE with read data 0.
  - ISSUE drives `arb_re`/`arb_we` for the current beat and holds them until `in_arb_finish`.
    - On finish with more beats: advance the beat, stay in ISSUE, and deassert `arb_re`/`arb_we` for one cycle (a bubble).
    - On the last beat: go to DONE.
  - DONE pulses `in_core_finish` for 1 cycle, then → IDLE.
- Beat format (32-bit):
  - `arb_addr` = {addr[63:3], beat, 2'b00}.
  - `arb_data[31:0]` = selected word; upper 32 bits are 0.
  - `arb_mask` = {4'b0, selected nibble}.
  - Read word is taken from `in_arb_data[31:0]` into half `beat` of the data register. Unread half = 0.
- Beat format (64-bit): addr, data and mask pass through as captured; read = `in_arb_data`.
- `in_core_data` on the uncached path = assembled register, held until the next uncached request is captured.
- `in_arb_finish` outside ISSUE is ignored.

## Timing
- Reset values: all registered outputs are 0, FSM is in IDLE, the data register is 0.
- Reset mid-operation aborts any beat in flight with no core completion.
- Latency: capture at edge 0, LOAD at edge 1, first `arb_*` request is visible after edge 1.
  - `in_core_finish` is high in the cycle after the edge that samples the last `in_arb_finish`.
- The core holds its request stable until `in_core_finish`. Request still asserted in the cycle after DONE = new access.
- Mid-access address change: ignored, because the captured copy is used.

## Structure
- Shared package `uncache_pkg`:
  - state enum IDLE/LOAD/ISSUE/DONE;
  - `MMIO_SIGN_CLINT`=3'b010, `MMIO_SIGN_MEM`=3'b100;
  - default region constants.
- Sub-module `region_decode` (parametrised `NUM_RGN`): outputs hit vector and `uncache`.
- Top module holds the FSM, beat counter and data/mask registers.

## Test plan
- UART read 0x1000_0000, mask 8'hFF, `BUS_W`=32:
  - beats at 0x1000_0000 then 0x1000_0004, with `arb_mask` 8'h0F each;
  - arb returns 0x11223344 then 0x55667788;
  - `in_core_data` = 0x55667788_11223344 with a 1-cycle finish.
- UART write of a single byte, mask 8'h10 → exactly one beat at addr+4, `arb_mask` 8'h01, `arb_data`[7:0] = core_data[39:32].
- Cached read 0x8000_0000 → `dcache_re`=1 in the same cycle, `arb_re` stays 0, `in_core_finish` follows `in_dcache_finish`.
- CLINT access 0x0200_4000 → `mmio_sign` = 3'b010; a non-CLINT access gives 3'b100.
- Reset pulled during ISSUE with `in_arb_finish` low → FSM in IDLE and all outputs 0 on the following cycle; no `in_core_finish`.
- Uncached access with mask 8'h00 → zero arb beats and `in_core_finish` 2 cycles after capture with data 0.

Source files
------------

// File: rtl/uncache_pkg.sv
// rtl/uncache_pkg.sv - shared types and default MMIO region map for the uncached splitter
package uncache_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_ISSUE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] MMIO_SIGN_CLINT = 3'b010;
    localparam logic [2:0] MMIO_SIGN_MEM   = 3'b100;

    localparam logic [63:0] UART_BASE    = 64'h0000_0000_1000_0000;
    localparam logic [63:0] UART_END     = 64'h0000_0000_1000_0fff;
    localparam logic [63:0] SPICTRL_BASE = 64'h0000_0000_1000_1000;
    localparam logic [63:0] SPICTRL_END  = 64'h0000_0000_1000_1fff;
    localparam logic [63:0] SPI_BASE     = 64'h0000_0000_3000_0000;
    localparam logic [63:0] SPI_END      = 64'h0000_0000_3fff_ffff;
    localparam logic [63:0] CLINT_BASE   = 64'h0000_0000_0200_0000;
    localparam logic [63:0] CLINT_END    = 64'h0000_0000_0200_ffff;

    localparam int DEF_NUM_RGN = 4;
    localparam logic [DEF_NUM_RGN*64-1:0] DEF_RGN_BASE = {CLINT_BASE, SPI_BASE, SPICTRL_BASE, UART_BASE};
    localparam logic [DEF_NUM_RGN*64-1:0] DEF_RGN_END  = {CLINT_END, SPI_END, SPICTRL_END, UART_END};

endpackage

// File: rtl/region_decode.sv
// rtl/region_decode.sv - inclusive base/end range match against a packed region table
module region_decode #(
    parameter int                    NUM_RGN  = 4,
    parameter logic [NUM_RGN*64-1:0] RGN_BASE = '0,
    parameter logic [NUM_RGN*64-1:0] RGN_END  = '0
) (
    input  logic [63:0]        addr,
    output logic [NUM_RGN-1:0] hit,
    output logic               uncache
);

    for (genvar i = 0; i < NUM_RGN; i++) begin : g_rgn
        assign hit[i] = (addr >= RGN_BASE[64*i +: 64]) && (addr <= RGN_END[64*i +: 64]);
    end

    assign uncache = |hit;

endmodule

// File: rtl/uncache_mmio_split.sv
// rtl/uncache_mmio_split.sv - LSU splitter: cached requests to dcache, uncached ones serialised onto the arbiter
module uncache_mmio_split
    import uncache_pkg::*;
#(
    parameter int                    BUS_W     = 32,
    parameter int                    NUM_RGN   = DEF_NUM_RGN,
    parameter logic [NUM_RGN*64-1:0] RGN_BASE  = DEF_RGN_BASE,
    parameter logic [NUM_RGN*64-1:0] RGN_END   = DEF_RGN_END,
    parameter int                    CLINT_RGN = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [2:0]  mmio_sign,
    input  logic [63:0] core_addr,
    input  logic [63:0] core_data,
    input  logic [7:0]  core_mask,
    input  logic        core_we,
    input  logic        core_re,
    input  logic        fence_in,
    output logic [63:0] in_core_data,
    output logic        in_core_finish,
    output logic [63:0] arb_addr,
    output logic [63:0] arb_data,
    output logic [7:0]  arb_mask,
    output logic        arb_we,
    output logic        arb_re,
    input  logic [63:0] in_arb_data,
    input  logic        in_arb_finish,
    output logic [63:0] dcache_addr,
    output logic [63:0] dcache_data,
    output logic [7:0]  dcache_mask,
    output logic        dcache_we,
    output logic        dcache_re,
    output logic        dcache_fence,
    input  logic [63:0] in_dcache_data,
    input  logic        in_dcache_finish
);

    localparam logic [NUM_RGN-1:0] CLINT_ONEHOT = NUM_RGN'(1) << CLINT_RGN;

    logic [NUM_RGN-1:0] hit;
    logic               uncache;
    logic               req;
    logic               uc_path;

    state_t      state;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [7:0]  mask_q;
    logic        we_q;
    logic [63:0] rdata_q;
    logic        beat_q;
    logic        more_q;
    logic        arb_re_q;
    logic        arb_we_q;
    logic        finish_q;

    logic [63:0] beat_addr;
    logic [63:0] beat_data;
    logic [7:0]  beat_mask;
    logic [63:0] rdata_next;

    region_decode #(
        .NUM_RGN  (NUM_RGN),
        .RGN_BASE (RGN_BASE),
        .RGN_END  (RGN_END)
    ) u_region_decode (
        .addr    (core_addr),
        .hit     (hit),
        .uncache (uncache)
    );

    assign req       = core_re | core_we;
    assign mmio_sign = (req && |(hit & CLINT_ONEHOT)) ? MMIO_SIGN_CLINT : MMIO_SIGN_MEM;

    // Once an uncached access is captured the response mux stays on it, even if the address moves.
    assign uc_path = uncache | (state != S_IDLE);

    assign dcache_addr  = uc_path ? '0 : core_addr;
    assign dcache_data  = uc_path ? '0 : core_data;
    assign dcache_mask  = uc_path ? '0 : core_mask;
    assign dcache_we    = uc_path ? 1'b0 : core_we;
    assign dcache_re    = uc_path ? 1'b0 : core_re;
    assign dcache_fence = fence_in;

    assign in_core_data   = uc_path ? rdata_q : in_dcache_data;
    assign in_core_finish = uc_path ? finish_q : in_dcache_finish;

    always_comb begin
        beat_addr  = addr_q;
        beat_data  = wdata_q;
        beat_mask  = mask_q;
        rdata_next = rdata_q;
        if (BUS_W == 64) begin
            rdata_next = in_arb_data;
        end else begin
            beat_addr = {addr_q[63:3], beat_q, 2'b00};
            beat_data = {32'b0, beat_q ? wdata_q[63:32] : wdata_q[31:0]};
            beat_mask = {4'b0, beat_q ? mask_q[7:4] : mask_q[3:0]};
            if (beat_q) rdata_next[63:32] = in_arb_data[31:0];
            else        rdata_next[31:0]  = in_arb_data[31:0];
        end
    end

    assign arb_re   = arb_re_q;
    assign arb_we   = arb_we_q;
    assign arb_addr = (arb_re_q | arb_we_q) ? beat_addr : '0;
    assign arb_data = (arb_re_q | arb_we_q) ? beat_data : '0;
    assign arb_mask = (arb_re_q | arb_we_q) ? beat_mask : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            mask_q   <= '0;
            we_q     <= 1'b0;
            rdata_q  <= '0;
            beat_q   <= 1'b0;
            more_q   <= 1'b0;
            arb_re_q <= 1'b0;
            arb_we_q <= 1'b0;
            finish_q <= 1'b0;
        end else begin
            finish_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (uncache && req) begin
                        addr_q  <= core_addr;
                        wdata_q <= core_data;
                        mask_q  <= core_mask;
                        we_q    <= core_we;
                        rdata_q <= '0;
                        state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (mask_q == 8'h00) begin
                        finish_q <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        // Low word first; a 32-bit bus skips any half whose byte enables are all clear.
                        if (BUS_W == 64) begin
                            beat_q <= 1'b0;
                            more_q <= 1'b0;
                        end else begin
                            beat_q <= ~|mask_q[3:0];
                            more_q <= (|mask_q[3:0]) & (|mask_q[7:4]);
                        end
                        arb_re_q <= ~we_q;
                        arb_we_q <= we_q;
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (arb_re_q | arb_we_q) begin
                        if (in_arb_finish) begin
                            arb_re_q <= 1'b0;
                            arb_we_q <= 1'b0;
                            if (!we_q) rdata_q <= rdata_next;
                            if (more_q) begin
                                beat_q <= 1'b1;
                                more_q <= 1'b0;
                            end else begin
                                finish_q <= 1'b1;
                                state    <= S_DONE;
                            end
                        end
                    end else begin
                        arb_re_q <= ~we_q;
                        arb_we_q <= we_q;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uncache_mmio_split.sv
// tb/tb_uncache_mmio_split.sv - randomized self-checking bench for uncache_mmio_split against a beat-list model
module tb_uncache_mmio_split;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  mmio_sign;
    logic [63:0] core_addr = '0, core_data = '0;
    logic [7:0]  core_mask = '0;
    logic        core_we = 1'b0, core_re = 1'b0, fence_in = 1'b0;
    logic [63:0] in_core_data;
    logic        in_core_finish;
    logic [63:0] arb_addr, arb_data;
    logic [7:0]  arb_mask;
    logic        arb_we, arb_re;
    logic [63:0] in_arb_data = '0;
    logic        in_arb_finish = 1'b0;
    logic [63:0] dcache_addr, dcache_data;
    logic [7:0]  dcache_mask;
    logic        dcache_we, dcache_re, dcache_fence;
    logic [63:0] in_dcache_data = '0;
    logic        in_dcache_finish = 1'b0;

    int total = 0;
    int bad = 0;

    logic [63:0] rgn_lo [4] = '{64'h1000_0000, 64'h1000_1000, 64'h3000_0000, 64'h0200_0000};
    logic [63:0] rgn_hi [4] = '{64'h1000_0fff, 64'h1000_1fff, 64'h3fff_ffff, 64'h0200_ffff};

    uncache_mmio_split dut (
        .clk(clk), .rst_n(rst_n), .mmio_sign(mmio_sign),
        .core_addr(core_addr), .core_data(core_data), .core_mask(core_mask),
        .core_we(core_we), .core_re(core_re), .fence_in(fence_in),
        .in_core_data(in_core_data), .in_core_finish(in_core_finish),
        .arb_addr(arb_addr), .arb_data(arb_data), .arb_mask(arb_mask),
        .arb_we(arb_we), .arb_re(arb_re),
        .in_arb_data(in_arb_data), .in_arb_finish(in_arb_finish),
        .dcache_addr(dcache_addr), .dcache_data(dcache_data), .dcache_mask(dcache_mask),
        .dcache_we(dcache_we), .dcache_re(dcache_re), .dcache_fence(dcache_fence),
        .in_dcache_data(in_dcache_data), .in_dcache_finish(in_dcache_finish)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int region_of(input logic [63:0] a);
        for (int i = 0; i < 4; i++)
            if (a >= rgn_lo[i] && a <= rgn_hi[i]) return i;
        return -1;
    endfunction

    task automatic uc_access(input logic [63:0] a, input logic [63:0] d, input logic [7:0] m,
                             input bit we, input logic [31:0] rw0, input logic [31:0] rw1);
        logic [63:0] exp_addr [$];
        logic [63:0] exp_wdata [$];
        logic [7:0]  exp_mask [$];
        int          exp_half [$];
        logic [63:0] exp_rd;
        logic [31:0] word;
        int nb, bi, c, wait_left, last_fin;
        bit done, seen;
        exp_rd = '0;
        for (int b = 0; b < 2; b++) begin
            if (m[4*b +: 4] != 4'h0) begin
                exp_addr.push_back({a[63:3], 1'(b), 2'b00});
                exp_wdata.push_back({32'b0, d[32*b +: 32]});
                exp_mask.push_back({4'b0, m[4*b +: 4]});
                exp_half.push_back(b);
            end
        end
        nb = exp_addr.size();
        bi = 0; last_fin = 0; done = 0; seen = 0;
        wait_left = $urandom_range(0, 2);
        @(posedge clk); #1;
        core_addr = a; core_data = d; core_mask = m; core_we = we; core_re = !we;
        for (c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (c == 0) begin
                check("mmio_sign", {61'b0, mmio_sign}, (region_of(a) == 3) ? 64'b010 : 64'b100);
                check("dcache_gated", {62'b0, dcache_we, dcache_re}, 64'd0);
            end
            if (in_core_finish) begin
                check("beat_count", 64'(bi), 64'(nb));
                check("finish_cycle", 64'(c), (nb == 0) ? 64'd2 : 64'(last_fin + 1));
                check("core_rdata", in_core_data, we ? 64'd0 : exp_rd);
                in_arb_finish = 1'b0;
                done = 1;
            end else if (arb_re || arb_we) begin
                if (bi >= nb) begin
                    check("extra_beat", 64'(bi + 1), 64'(nb));
                    done = 1;
                end else begin
                    if (!seen) begin
                        check("beat_start", 64'(c), (bi == 0) ? 64'd2 : 64'(last_fin + 2));
                        seen = 1;
                    end
                    check("arb_dir", {62'b0, arb_we, arb_re}, we ? 64'b10 : 64'b01);
                    check("arb_addr", arb_addr, exp_addr[bi]);
                    check("arb_mask", {56'b0, arb_mask}, {56'b0, exp_mask[bi]});
                    if (we) check("arb_data", arb_data, exp_wdata[bi]);
                    if (wait_left == 0) begin
                        word = (exp_half[bi] == 1) ? rw1 : rw0;
                        in_arb_finish = 1'b1;
                        in_arb_data = {$urandom, word};
                        if (!we) exp_rd[32*exp_half[bi] +: 32] = word;
                        last_fin = c;
                        bi++;
                        seen = 0;
                        wait_left = $urandom_range(0, 2);
                    end else begin
                        wait_left--;
                        in_arb_finish = 1'b0;
                        in_arb_data = {$urandom, $urandom};
                    end
                end
            end else begin
                in_arb_finish = (c < 2) ? 1'($urandom_range(0, 1)) : 1'b0;
                in_arb_data = {$urandom, $urandom};
            end
        end
        if (!done) check("finish_timeout", 64'(done), 64'd1);
        @(posedge clk); #1;
        core_re = 1'b0; core_we = 1'b0; in_arb_finish = 1'b0;
        @(negedge clk);
        check("finish_pulse", {63'b0, in_core_finish}, 64'd0);
        check("rdata_hold", in_core_data, we ? 64'd0 : exp_rd);
    endtask

    task automatic cached_access(input logic [63:0] a);
        logic [63:0] d, rd;
        logic [7:0]  m;
        bit          we, fn;
        d = {$urandom, $urandom}; rd = {$urandom, $urandom};
        m = 8'($urandom); we = 1'($urandom_range(0, 1)); fn = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        core_addr = a; core_data = d; core_mask = m; core_we = we; core_re = !we;
        fence_in = fn; in_dcache_data = rd; in_dcache_finish = 1'b0;
        @(negedge clk);
        check("dc_addr", dcache_addr, a);
        check("dc_data", dcache_data, d);
        check("dc_mask", {56'b0, dcache_mask}, {56'b0, m});
        check("dc_dir", {62'b0, dcache_we, dcache_re}, we ? 64'b10 : 64'b01);
        check("dc_fence", {63'b0, dcache_fence}, {63'b0, fn});
        check("dc_mmio_sign", {61'b0, mmio_sign}, 64'b100);
        check("dc_no_finish", {63'b0, in_core_finish}, 64'd0);
        @(posedge clk); #1;
        in_dcache_finish = 1'b1;
        @(negedge clk);
        check("dc_finish", {63'b0, in_core_finish}, 64'd1);
        check("dc_rdata", in_core_data, rd);
        check("dc_no_arb", {62'b0, arb_we, arb_re}, 64'd0);
        @(posedge clk); #1;
        core_re = 1'b0; core_we = 1'b0; in_dcache_finish = 1'b0; fence_in = 1'b0;
        @(negedge clk);
        check("dc_idle_arb", {62'b0, arb_we, arb_re}, 64'd0);
    endtask

    task automatic reset_mid_issue();
        @(posedge clk); #1;
        core_addr = 64'h1000_0008; core_data = '0; core_mask = 8'hff; core_re = 1'b1; core_we = 1'b0;
        in_arb_finish = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pre_issue", {63'b0, arb_re}, 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_arb_dir", {62'b0, arb_we, arb_re}, 64'd0);
        check("rst_arb_addr", arb_addr, 64'd0);
        check("rst_arb_mask", {56'b0, arb_mask}, 64'd0);
        check("rst_finish", {63'b0, in_core_finish}, 64'd0);
        check("rst_rdata", in_core_data, 64'd0);
        @(posedge clk); #1;
        core_re = 1'b0; in_arb_finish = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_finish", {63'b0, in_core_finish}, 64'd0);
            check("post_rst_arb", {62'b0, arb_we, arb_re}, 64'd0);
        end
        in_arb_finish = 1'b0;
    endtask

    initial begin
        logic [63:0] a;
        int r, kind;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_arb", {62'b0, arb_we, arb_re}, 64'd0);
        check("reset_finish", {63'b0, in_core_finish}, 64'd0);
        check("reset_rdata", in_core_data, 64'd0);
        rst_n = 1'b1;

        uc_access(64'h1000_0000, {$urandom, $urandom}, 8'hff, 0, 32'h1122_3344, 32'h5566_7788);
        uc_access(64'h1000_0000, 64'h0123_4567_89ab_cdef, 8'h10, 1, 32'h0, 32'h0);
        cached_access(64'h8000_0000);
        uc_access(64'h0200_4000, {$urandom, $urandom}, 8'h0f, 0, $urandom, $urandom);
        uc_access(64'h1000_0010, {$urandom, $urandom}, 8'h00, 0, $urandom, $urandom);
        reset_mid_issue();

        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 3);
            kind = $urandom_range(0, 5);
            case (kind)
                0:       a = rgn_lo[r];
                1:       a = rgn_hi[r];
                2:       a = rgn_hi[r] + 64'd1;
                3:       a = rgn_lo[r] - 64'd1;
                4:       a = 64'h8000_0000 + {32'b0, $urandom};
                default: a = rgn_lo[r] + 64'($urandom_range(0, 255) * 8 + $urandom_range(0, 7));
            endcase
            if (region_of(a) >= 0)
                uc_access(a, {$urandom, $urandom}, 8'($urandom), 1'($urandom_range(0, 1)), $urandom, $urandom);
            else
                cached_access(a);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
